vector_mem_unit: RTL and testbench



---
 rtl/vector_mem_unit.sv | 158 +++++++++++++++
 tb/tb_vector_mem_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_unit.sv
// Vector load/store unit.
// A load reads vectorSize elements from byte-wide synchronous memory, packs
// them into one vector and writes that vector to the register file with a
// single wEnable pulse. A store writes a latched vector to memory, one
// element per cycle. Element 0 sits at the lowest address.
module vector_mem_unit #(
  parameter int elementSize = 8,
  parameter int vectorSize  = 8,
  parameter int addrWidth   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              isStore,
  input  logic [addrWidth-1:0]              baseAddr,
  input  logic [1:0]                        vreg,
  input  logic [elementSize*vectorSize-1:0] storeData,
  output logic [addrWidth-1:0]              memAddr,
  output logic                              memRead,
  output logic                              memWrite,
  output logic [elementSize-1:0]            memWData,
  input  logic [elementSize-1:0]            memRData,
  output logic                              wEnable,
  output logic [1:0]                        vresult,
  output logic [elementSize*vectorSize-1:0] dataIn,
  output logic                              busy,
  output logic                              done
);

  localparam int VEC_W = elementSize * vectorSize;
  localparam int IDX_W = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(vectorSize - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LCAPT = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_SDONE = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [VEC_W-1:0]     vec_q,   vec_d;
  logic [addrWidth-1:0] base_q,  base_d;
  logic [1:0]           vreg_q,  vreg_d;
  logic [VEC_W-1:0]     sdata_q, sdata_d;

  // Control state and the assembled vector; cleared by reset so an aborted
  // load leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  // Command operands latched at start; only observed in active states.
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    vreg_q  <= vreg_d;
    sdata_q <= sdata_d;
  end

  // Sequencing: accept a command in IDLE, walk idx across the vector, and
  // capture read data one cycle behind its request (memory latency is 1).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    base_d  = base_q;
    vreg_d  = vreg_q;
    sdata_d = sdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = baseAddr;
          vreg_d  = vreg;
          sdata_d = storeData;
          idx_d   = '0;
          state_d = isStore ? S_STORE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (idx_q != '0) begin
          vec_d[elementSize*int'(idx_q - 1'b1) +: elementSize] = memRData;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_LCAPT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_LCAPT: begin
        // Last element's data arrives the cycle after its request.
        vec_d[elementSize*(vectorSize-1) +: elementSize] = memRData;
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      S_STORE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_SDONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_SDONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode purely from state so they hold steady for a full cycle
  // and are zero whenever the unit is not in the state that owns them.
  always_comb begin
    memAddr  = '0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memWData = '0;
    wEnable  = 1'b0;
    vresult  = '0;
    dataIn   = '0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        memRead = 1'b1;
        memAddr = base_q + addrWidth'(idx_q);
      end
      S_WB: begin
        wEnable = 1'b1;
        vresult = vreg_q;
        dataIn  = vec_q;
        done    = 1'b1;
      end
      S_STORE: begin
        memWrite = 1'b1;
        memAddr  = base_q + addrWidth'(idx_q);
        memWData = sdata_q[elementSize*int'(idx_q) +: elementSize];
      end
      S_SDONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Bench for vector_mem_unit: directed plan scenarios followed by random
// load/store commands, checked against a byte-array memory reference.
module tb_vector_mem_unit;

  localparam int ES = 8;
  localparam int VS = 8;
  localparam int AW = 16;
  localparam int VW = ES * VS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          isStore;
  logic [AW-1:0] baseAddr;
  logic [1:0]    vreg;
  logic [VW-1:0] storeData;
  logic [AW-1:0] memAddr;
  logic          memRead;
  logic          memWrite;
  logic [ES-1:0] memWData;
  logic [ES-1:0] memRData = '0;
  logic          wEnable;
  logic [1:0]    vresult;
  logic [VW-1:0] dataIn;
  logic          busy;
  logic          done;

  // Environment: data memory and register file.
  logic [7:0]    mem [0:65535];
  bit            mem_ready = 1'b0;
  logic [VW-1:0] rf [0:3] = '{default: '0};
  int            wen_count = 0;

  // Reference: expected memory contents.
  logic [7:0]    ref_mem [0:65535];

  int total  = 0;
  int passed = 0;

  vector_mem_unit #(.elementSize(ES), .vectorSize(VS), .addrWidth(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .isStore(isStore),
    .baseAddr(baseAddr), .vreg(vreg), .storeData(storeData),
    .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
    .memWData(memWData), .memRData(memRData), .wEnable(wEnable),
    .vresult(vresult), .dataIn(dataIn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seed_byte(input int a);
    if (a >= 16'h0100 && a <= 16'h0107) return 8'(a - 16'h00FF);
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5A);
  endfunction

  // Synchronous byte memory, one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 65536; a++) mem[a] <= seed_byte(a);
      mem_ready <= 1'b1;
    end else begin
      if (memWrite) mem[memAddr] <= memWData;
      if (memRead)  memRData <= mem[memAddr];
    end
  end

  // Register file writes on the falling edge.
  always @(negedge clk) begin
    if (wEnable) begin
      rf[vresult] <= dataIn;
      wen_count   <= wen_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {busy, done, memRead, memWrite, wEnable, vresult, memAddr, memWData}, 64'd0);
    chk({tag, "_dataIn"}, dataIn, 64'd0);
  endtask

  // Issue one command in the current cycle and check it cycle by cycle.
  // Ends in the cycle after done. With hold=1, start stays high carrying
  // a different command while the unit is busy.
  task automatic run_cmd(input bit st, input logic [15:0] base, input logic [1:0] vr,
                         input logic [63:0] data, input bit hold = 1'b0);
    logic [63:0] expv;
    logic [63:0] memv;
    logic [15:0] a;
    start = 1'b1; isStore = st; baseAddr = base; vreg = vr; storeData = data;
    step();
    if (hold) begin
      baseAddr = base ^ 16'h0F0F;
      vreg     = ~vr;
    end else begin
      start     = 1'b0;
      isStore   = 1'($urandom);
      baseAddr  = 16'($urandom);
      vreg      = 2'($urandom);
      storeData = {$urandom, $urandom};
    end
    for (int c = 0; c < VS; c++) begin
      a = base + 16'(c);
      chk("busy_active", busy, 1'b1);
      chk(st ? "strobe_store" : "strobe_load", {memRead, memWrite}, st ? 2'b01 : 2'b10);
      chk("mem_addr", memAddr, a);
      if (st) chk("mem_wdata", memWData, data[8*c +: 8]);
      chk("no_wen_done_early", {wEnable, done}, 2'b00);
      if (c < VS - 1) step();
    end
    step();
    if (st) begin
      chk("store_done", {done, busy, memRead, memWrite, wEnable}, 5'b11000);
      chk("store_idle_bus", {memAddr, memWData}, 24'd0);
      for (int i = 0; i < VS; i++) begin
        ref_mem[base + 16'(i)] = data[8*i +: 8];
        memv[8*i +: 8] = mem[base + 16'(i)];
      end
      chk("store_mem_content", memv, data);
    end else begin
      chk("lcapt_quiet", {busy, done, memRead, memWrite, wEnable}, 5'b10000);
      step();
      for (int i = 0; i < VS; i++) expv[8*i +: 8] = ref_mem[base + 16'(i)];
      chk("wb_strobes", {wEnable, done, memRead, memWrite}, 4'b1100);
      chk("wb_vresult", vresult, vr);
      chk("wb_dataIn", dataIn, expv);
    end
    step();
    chk("after_done_idle", {busy, done, wEnable, memRead, memWrite}, 5'b00000);
    if (!st) chk("rf_readback", rf[vr], expv);
  endtask

  initial begin
    logic [63:0] snap;
    int          wc;
    logic [15:0] b;
    logic [63:0] d;
    bit          s;

    for (int a = 0; a < 65536; a++) ref_mem[a] = seed_byte(a);
    rst_n = 1'b0; start = 1'b0; isStore = 1'b0; baseAddr = '0; vreg = '0; storeData = '0;
    repeat (3) step();
    chk_quiet("reset_outputs");
    rst_n = 1'b1;
    step();
    chk_quiet("idle_after_reset");

    // Load 01..08 from 0x0100 into vreg 2.
    run_cmd(1'b0, 16'h0100, 2'd2, 64'd0);
    chk("plan_load_value", rf[2], 64'h0807060504030201);

    // Store to 0x0200.
    wc = wen_count;
    run_cmd(1'b1, 16'h0200, 2'd0, 64'h1122334455667788);
    chk("store_no_wen", wen_count, wc);

    // Address wrap.
    run_cmd(1'b0, 16'hFFFC, 2'd3, 64'd0);

    // Start held high: second command taken the cycle after done.
    run_cmd(1'b0, 16'h0100, 2'd0, 64'd0, 1'b1);
    run_cmd(1'b0, 16'h0100 ^ 16'h0F0F, 2'd3, 64'd0);

    // Reset in cycle 5 of a load.
    snap = rf[1];
    wc   = wen_count;
    start = 1'b1; isStore = 1'b0; baseAddr = 16'h0400; vreg = 2'd1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("mid_load_reading", memRead, 1'b1);
    rst_n = 1'b0;
    step();
    chk_quiet("abort_outputs");
    rst_n = 1'b1;
    repeat (14) begin
      step();
    end
    chk("abort_no_wen", wen_count, wc);
    chk("abort_rf_kept", rf[1], snap);
    chk("abort_idle", busy, 1'b0);

    // Store then load back with one idle cycle between.
    d = 64'hA5C3_0F96_3C5A_E718;
    run_cmd(1'b1, 16'h0300, 2'd0, d);
    run_cmd(1'b0, 16'h0300, 2'd1, 64'd0);
    chk("b2b_roundtrip", rf[1], d);

    // Random commands.
    for (int n = 0; n < 24; n++) begin
      s = 1'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'hFFF8 + 16'($urandom_range(0, 7));
      else                           b = 16'($urandom);
      d = {$urandom, $urandom};
      run_cmd(s, b, 2'($urandom), d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
